// File: rtl/wlo_err_acc.sv
// Error-statistics accumulator: sum of squared errors and max |dut - ref| over a programmed batch.
// Three-stage pipeline (diff, square/abs, accumulate) behind a small batch-control FSM.
module wlo_err_acc #(
  parameter int unsigned DATA_W = 29,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned ACC_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] dut_data,
  input  logic [DATA_W-1:0] ref_data,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  sse,
  output logic [DATA_W:0]   max_abs_err,
  output logic              sat
);

  localparam int unsigned DIFF_W = DATA_W + 1;
  localparam int unsigned SQ_W   = 2 * DIFF_W;
  // One guard bit above the wider of accumulator and square catches any overflow.
  localparam int unsigned SUM_W  = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e             r_state;
  logic [CNT_W-1:0]   r_num;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_in_ready;
  logic               r_busy;
  logic               r_done;

  logic               r_v1;
  logic [DIFF_W-1:0]  r_diff;
  logic               r_v2;
  logic [SQ_W-1:0]    r_sq;
  logic [DIFF_W-1:0]  r_abs;
  logic [ACC_W-1:0]   r_sse;
  logic [DATA_W:0]    r_max;
  logic               r_sat;

  logic               w_accept;
  logic               w_start_acc;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [SQ_W-1:0]    w_diff_ext;
  logic [SQ_W-1:0]    w_sq;
  logic [DIFF_W-1:0]  w_abs;
  logic [SUM_W-1:0]   w_sum;
  logic               w_ovf;

  assign w_accept    = in_valid && r_in_ready;
  assign w_start_acc = start && ((r_state == StIdle) || (r_state == StDone));
  assign w_cnt_nxt   = r_cnt + CNT_W'(1);

  // Low SQ_W bits of the sign-extended product are the exact square since |diff|^2 < 2^(SQ_W-1).
  assign w_diff_ext  = {{DIFF_W{r_diff[DIFF_W-1]}}, r_diff};
  assign w_sq        = w_diff_ext * w_diff_ext;
  assign w_abs       = r_diff[DIFF_W-1] ? (~r_diff + DIFF_W'(1)) : r_diff;
  assign w_sum       = SUM_W'(r_sse) + SUM_W'(r_sq);
  assign w_ovf       = |w_sum[SUM_W-1:ACC_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_num      <= '0;
      r_cnt      <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_num  <= num_samples;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (num_samples == '0) begin
              r_state    <= StDrain;
              r_in_ready <= 1'b0;
            end else begin
              r_state    <= StRun;
              r_in_ready <= 1'b1;
            end
          end
        end
        StRun: begin
          if (w_accept) begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == r_num) begin
              r_state    <= StDrain;
              r_in_ready <= 1'b0;
            end
          end
        end
        StDrain: begin
          // Stage 3 writes the accumulators directly, so only S1/S2 must be empty.
          if (!r_v1 && !r_v2) begin
            r_state <= StDone;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_diff <= '0;
      r_v2   <= 1'b0;
      r_sq   <= '0;
      r_abs  <= '0;
      r_sse  <= '0;
      r_max  <= '0;
      r_sat  <= 1'b0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_diff <= {dut_data[DATA_W-1], dut_data} - {ref_data[DATA_W-1], ref_data};
      end
      r_v2 <= r_v1;
      if (r_v1) begin
        r_sq  <= w_sq;
        r_abs <= w_abs;
      end
      if (w_start_acc) begin
        r_sse <= '0;
        r_max <= '0;
        r_sat <= 1'b0;
      end else if (r_v2) begin
        if (w_ovf) begin
          r_sse <= '1;
          r_sat <= 1'b1;
        end else begin
          r_sse <= w_sum[ACC_W-1:0];
        end
        if (r_abs > r_max) begin
          r_max <= r_abs;
        end
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign sse         = r_sse;
  assign max_abs_err = r_max;
  assign sat         = r_sat;

endmodule
